demux_stream: RTL and testbench
===============================

// Module: demux_stream
// PURPOSE
//  - 1-to-2 registered stream demultiplexer; the inverse of the 2:1 byte mux path.
//  - Routes each input word to out0 or out1 according to in_sel.
//  - Each output has a one-entry holding slot, so a stalled sink does not block the other.
//  - Sits between a single byte producer and two independent consumers.
// PARAMETERS
//  - WIDTH    8   data width of in_data/out0_data/out1_data
//  - COUNT_W  16  width of the per-output transfer counters (only with DEMUX_COUNT_EN)
// PORTS
//  - clk         in   1        rising-edge clock, single domain
//  - rst_n       in   1        asynchronous active-low reset
//  - in_data     in   WIDTH    input word
//  - in_sel      in   1        destination: 0 -> out0, 1 -> out1
//  - in_valid    in   1        in_data/in_sel valid
//  - in_ready    out  1        demux accepts the word this cycle
//  - out0_data   out  WIDTH    slot 0 word
//  - out0_valid  out  1        slot 0 full
//  - out0_ready  in   1        sink 0 accepts
//  - out1_data   out  WIDTH    slot 1 word
//  - out1_valid  out  1        slot 1 full
//  - out1_ready  in   1        sink 1 accepts
//  - cnt0        out  COUNT_W  words delivered on out0 (DEMUX_COUNT_EN only)
//  - cnt1        out  COUNT_W  words delivered on out1 (DEMUX_COUNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - both slots EMPTY; outN_valid=0, outN_data=0.
//    - cnt0/cnt1 = 0.
//    - in_ready=0 while rst_n=0.
//  - Per-slot FSM, states EMPTY and FULL. Transitions:
//    - EMPTY -> FULL on load.
//    - FULL -> EMPTY on drain with no load.
//    - FULL -> FULL on simultaneous drain and load; slot takes the new word.
//  - Handshake rules:
//    - load_N  = in_valid & in_ready & (in_sel==N).
//    - drain_N = outN_valid & outN_ready.
//    - in_ready = rst_n & (~full[in_sel] | outN_ready[in_sel]).
//    - in_ready is combinational on in_sel and the selected outN_ready only.
//  - Latency: a word accepted at edge k appears with outN_valid=1 after edge k. One cycle, no bypass.
//  - Stability: while outN_valid=1 and outN_ready=0, outN_data must not change.
//  - Independence:
//    - a full, stalled slot 1 never lowers in_ready for in_sel=0, and vice versa.
//    - loading slot 0 and draining slot 1 in the same cycle is legal and independent.
//  - Ordering:
//    - per-destination order is preserved.
//    - no ordering guarantee between out0 and out1.
//  - in_valid=0: in_data and in_sel are don't-care; no state change except drains.
//  - Throughput: one word per cycle into a sink held ready.
//  - Reset mid-operation: any held word is discarded; no output handshake occurs during reset.
// CONFIGURATION
//  - DEMUX_COUNT_EN defined:
//    - cnt0/cnt1 ports exist.
//    - cntN increments by 1 on each drain_N.
//    - counters wrap from 2^COUNT_W-1 to 0 with no flag.
//  - DEMUX_COUNT_EN undefined:
//    - cnt0/cnt1 ports and counter logic are absent.
//    - all other behaviour is identical.
// STRUCTURE
//  - package demux_pkg:
//    - SLOT_EMPTY=1'b0, SLOT_FULL=1'b1 state encodings.
//    - DEF_WIDTH=8, DEF_COUNT_W=16.
//  - sub-module demux_slot:
//    - one-entry register stage with EMPTY/FULL FSM.
//    - ports: clk, rst_n, load, din, valid, ready, dout, can_load.
//    - instantiated twice (slot0, slot1).
//    - top level holds select decode, in_ready mux and optional counters.
// TESTING
//  - Reset: rst_n=0 mid-stream with out0_valid=1 -> out0_valid=0 and cnt0=0 immediately (async); in_ready=0.
//  - Routing: sinks ready; send 8'hA5 sel=0, then 8'h3C sel=1:
//    - out0_data=A5 valid one cycle after acceptance.
//    - out1_data=3C the following cycle.
//  - Blocking: out1_ready=0; send 8'h11 sel=1, then 8'h22 sel=1:
//    - second word sees in_ready=0; out1_data stays 11.
//    - a sel=0 word 8'h33 is accepted and delivered on out0 meanwhile.
//  - Simultaneous drain and load: slot0 holds 8'h44; out0_ready=1 while 8'h55 sel=0 arrives:
//    - in_ready=1; next cycle out0_data=55, out0_valid=1.
//  - Streaming: 256 words sel=0, out0_ready=1 -> in_ready=1 every cycle; data in order.
//  - Wrap (DEMUX_COUNT_EN, COUNT_W=4): 17 drains on out1 -> cnt1=1; cnt0=0.

Source files
------------

// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared encodings and default sizes for the demux_stream block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_COUNT_W = 16;

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module : demux_slot
// Brief  : One-entry holding register with EMPTY/FULL control for one output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             can_load
);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;

    assign w_drain  = (r_state == SLOT_FULL) && ready;
    assign valid    = (r_state == SLOT_FULL);
    assign dout     = r_data;
    // A full slot can still take a word in the same cycle its sink drains it.
    assign can_load = (r_state == SLOT_EMPTY) || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (load) begin
                        r_state <= SLOT_FULL;
                        r_data  <= din;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        r_state <= SLOT_FULL;
                        r_data  <= din;
                    end else if (w_drain) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: begin
                    r_state <= SLOT_EMPTY;
                end
            endcase
        end
    end

endmodule : demux_slot

`default_nettype wire

// File: rtl/demux_stream.sv
// ============================================================================
// Module : demux_stream
// Brief  : 1-to-2 registered stream demultiplexer with independent output
//          slots. Define DEMUX_COUNT_EN to add per-output delivery counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH
`ifdef DEMUX_COUNT_EN
    ,
    parameter int COUNT_W = DEF_COUNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out0_data,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic [WIDTH-1:0]   out1_data,
    output logic               out1_valid,
    input  logic               out1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1
`endif
);

    logic w_can_load0;
    logic w_can_load1;
    logic w_accept;
    logic w_load0;
    logic w_load1;

    // Only the selected slot gates acceptance, so a stalled sink never blocks the other.
    assign in_ready = rst_n && (in_sel ? w_can_load1 : w_can_load0);
    assign w_accept = in_valid && in_ready;
    assign w_load0  = w_accept && !in_sel;
    assign w_load1  = w_accept &&  in_sel;

    demux_slot #(
        .WIDTH    (WIDTH)
    ) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load0),
        .din      (in_data),
        .valid    (out0_valid),
        .ready    (out0_ready),
        .dout     (out0_data),
        .can_load (w_can_load0)
    );

    demux_slot #(
        .WIDTH    (WIDTH)
    ) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load1),
        .din      (in_data),
        .valid    (out1_valid),
        .ready    (out1_ready),
        .dout     (out1_data),
        .can_load (w_can_load1)
    );

`ifdef DEMUX_COUNT_EN
    logic [COUNT_W-1:0] r_cnt0;
    logic [COUNT_W-1:0] r_cnt1;

    // Counters wrap silently at 2^COUNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                r_cnt0 <= r_cnt0 + COUNT_W'(1);
            end
            if (out1_valid && out1_ready) begin
                r_cnt1 <= r_cnt1 + COUNT_W'(1);
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule : demux_stream

`default_nettype wire

// File: tb/tb_demux_stream.sv
// ============================================================================
// Module : tb_demux_stream
// Brief  : Scoreboard bench for demux_stream; per-destination expected-word
//          queues model the slots. Counter checks apply with DEMUX_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_stream;

    localparam int TB_COUNT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready = 1'b0;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
    logic [TB_COUNT_W-1:0] cnt0;
    logic [TB_COUNT_W-1:0] cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_cnt0 = 0;
    int         m_cnt1 = 0;
    logic       e_rdy;

    demux_stream #(
        .WIDTH      (8)
`ifdef DEMUX_COUNT_EN
        ,
        .COUNT_W    (TB_COUNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setin(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are stable at the falling edge, so the handshakes seen
    // here are exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out0_valid", out0_valid, 0);
            chk("rst_out1_valid", out1_valid, 0);
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            e_rdy = in_sel ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
            chk("in_ready", in_ready, e_rdy);
            chk("out0_valid", out0_valid, q0.size() != 0);
            chk("out1_valid", out1_valid, q1.size() != 0);
            if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
            if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
`ifdef DEMUX_COUNT_EN
            chk("cnt0", cnt0, m_cnt0 % (1 << TB_COUNT_W));
            chk("cnt1", cnt1, m_cnt1 % (1 << TB_COUNT_W));
`endif
            if (q0.size() != 0 && out0_ready) begin
                void'(q0.pop_front());
                m_cnt0++;
            end
            if (q1.size() != 0 && out1_ready) begin
                void'(q1.pop_front());
                m_cnt1++;
            end
            if (in_valid && e_rdy) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out0_valid", out0_valid, 0);
        chk("async_rst_in_ready", in_ready, 0);
`ifdef DEMUX_COUNT_EN
        chk("async_rst_cnt0", cnt0, 0);
`endif
        tick();
        tick();
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #3;
        chk("init_in_ready", in_ready, 0);
        chk("init_out0_valid", out0_valid, 0);
        chk("init_out0_data", out0_data, 0);
        chk("init_out1_data", out1_data, 0);
        #10;
        rst_n = 1'b1;
        tick();

        // Routing
        setin(1, 0, 8'hA5, 1, 1);
        tick();
        chk("route_out0_valid", out0_valid, 1);
        chk("route_out0_data", out0_data, 8'hA5);
        setin(1, 1, 8'h3C, 1, 1);
        tick();
        chk("route_out1_valid", out1_valid, 1);
        chk("route_out1_data", out1_data, 8'h3C);
        setin(0, 0, 8'h00, 1, 1);
        tick();

        // Blocking on a stalled out1 while out0 keeps flowing
        setin(1, 1, 8'h11, 1, 0);
        tick();
        setin(1, 1, 8'h22, 1, 0);
        #1;
        chk("block_in_ready", in_ready, 0);
        tick();
        chk("block_out1_hold", out1_data, 8'h11);
        setin(1, 0, 8'h33, 1, 0);
        #1;
        chk("indep_in_ready", in_ready, 1);
        tick();
        chk("indep_out0_data", out0_data, 8'h33);
        chk("indep_out1_hold", out1_data, 8'h11);
        setin(0, 0, 8'h00, 1, 1);
        tick();
        tick();

        // Simultaneous drain and load
        setin(1, 0, 8'h44, 0, 1);
        tick();
        setin(1, 0, 8'h55, 1, 1);
        #1;
        chk("simul_in_ready", in_ready, 1);
        chk("simul_old_data", out0_data, 8'h44);
        tick();
        chk("simul_new_valid", out0_valid, 1);
        chk("simul_new_data", out0_data, 8'h55);
        setin(0, 0, 8'h00, 1, 1);
        tick();

        // Streaming at full rate
        for (int i = 0; i < 256; i++) begin
            setin(1, 0, 8'(i), 1, 0);
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
        end
        setin(0, 0, 8'h00, 1, 1);
        tick();

        // Reset mid-stream with a held word
        setin(1, 0, 8'h77, 0, 0);
        tick();
        setin(0, 0, 8'h00, 0, 0);
        do_reset();

`ifdef DEMUX_COUNT_EN
        for (int i = 0; i < 17; i++) begin
            setin(1, 1, 8'(i + 1), 0, 1);
            tick();
        end
        setin(0, 0, 8'h00, 0, 1);
        tick();
        tick();
        chk("wrap_cnt1", cnt1, 1);
        chk("wrap_cnt0", cnt0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            setin($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            tick();
        end
        setin(0, 0, 8'h00, 1, 1);
        tick();
        tick();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux_stream

`default_nettype wire
